// File: rtl/wb_types_pkg.sv
// ---------------------------------------------------------------------------
// wb_types_pkg
//   Shared Wishbone B4 types for the burst-capable slaves.
//   - cti_e      : cycle type identifier encodings
//   - bte_e      : burst type extension encodings
//   - wb_state_e : slave FSM states (IDLE / SINGLE / BURST)
//   - wb_next_idx: next beat index for incrementing bursts, honouring BTE.
//     Works on a 32-bit index; callers truncate the result to their own
//     index width, which also provides the modulo wrap of linear bursts.
// ---------------------------------------------------------------------------
package wb_types_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } wb_state_e;

  localparam int WB_IDX_MAX_W = 32;

  // Wrapping bursts only advance the low bits selected by the wrap mask;
  // the upper bits stay anchored to the wrap window of the first beat.
  function automatic logic [WB_IDX_MAX_W-1:0] wb_next_idx(
    input logic [WB_IDX_MAX_W-1:0] idx,
    input bte_e                    bte
  );
    logic [WB_IDX_MAX_W-1:0] inc;
    logic [WB_IDX_MAX_W-1:0] m;
    inc = idx + 32'd1;
    case (bte)
      BTE_WRAP4:  m = 32'd3;
      BTE_WRAP8:  m = 32'd7;
      BTE_WRAP16: m = 32'd15;
      default:    m = 32'd0;
    endcase
    if (bte == BTE_LINEAR) begin
      return inc;
    end
    return (idx & ~m) | (inc & m);
  endfunction

endpackage

// File: rtl/wb_sram_mem.sv
// ---------------------------------------------------------------------------
// wb_sram_mem
//   DEPTH x DATA_W synchronous single-port RAM with per-byte write enables
//   and a registered read port. Contents are never reset.
//
//   clk    : clock, rising edge
//   rd_en  : load rdata with mem[addr] at this edge (otherwise rdata holds)
//   be     : per-byte write enables for mem[addr]
//   addr   : word address; caller guarantees addr < DEPTH when rd_en/be set
//   wdata  : write data
//   rdata  : registered read data
// ---------------------------------------------------------------------------
module wb_sram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read share the single address; a read on the same edge as a
  // write returns the old word, which the slave never relies on.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (be[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_burst_sram.sv
// ---------------------------------------------------------------------------
// wb_burst_sram
//   Wishbone B4 registered-feedback SRAM slave. Handles classic cycles and
//   incrementing bursts (CTI=010) with linear or wrap-4/8/16 BTE. One wait
//   state on the first beat, then one ACK per cycle. Upper address bits are
//   decoded upstream and ignored here; word indices at or beyond MEM_DEPTH
//   answer with ERR and never touch memory.
//
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (control only, RAM not reset)
//   s_adr    : byte address; only the word-index bits are used
//   s_dat_w  : write data, sampled in the ACK cycle
//   s_sel    : byte selects
//   s_cyc    : bus cycle
//   s_stb    : strobe
//   s_we     : write enable
//   s_cti    : cycle type identifier
//   s_bte    : burst type extension
//   s_dat_r  : read data (0 when no valid word is staged)
//   s_ack    : normal termination
//   s_err    : error termination (out-of-range word)
// ---------------------------------------------------------------------------
module wb_burst_sram
  import wb_types_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_ADDR_WIDTH-1:0]   s_adr,
  input  logic [WB_DATA_WIDTH-1:0]   s_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0] s_sel,
  input  logic                       s_cyc,
  input  logic                       s_stb,
  input  logic                       s_we,
  input  logic [2:0]                 s_cti,
  input  logic [1:0]                 s_bte,
  output logic [WB_DATA_WIDTH-1:0]   s_dat_r,
  output logic                       s_ack,
  output logic                       s_err
);

  localparam int NB       = WB_DATA_WIDTH / 8;
  localparam int LSB      = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_BITS = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int IW1      = IDX_BITS + 1;
  localparam logic [IDX_BITS:0] DEPTH_L = IW1'(MEM_DEPTH);

  wb_state_e           st;
  logic [IDX_BITS-1:0] idx;
  logic [IDX_BITS-1:0] idx_q;
  logic [IDX_BITS-1:0] idx_nxt;
  logic [IDX_BITS-1:0] ram_addr;
  logic                idx_oor;
  logic                cur_oor;
  logic                nxt_oor;
  logic                beat;
  logic                rd_vld_q;
  logic                ram_rd;
  logic                ram_wr;
  logic [NB-1:0]       ram_be;
  logic [WB_DATA_WIDTH-1:0] ram_rdata;
  logic                unused_adr;

  // Non-power-of-two depths leave a hole at the top of the index space.
  function automatic logic out_of_range(input logic [IDX_BITS-1:0] i);
    return {1'b0, i} >= DEPTH_L;
  endfunction

  assign idx        = s_adr[LSB+IDX_BITS-1:LSB];
  assign unused_adr = ^s_adr;

  assign idx_oor = out_of_range(idx);
  assign cur_oor = out_of_range(idx_q);
  assign nxt_oor = out_of_range(idx_nxt);

  // Truncation to IDX_BITS gives the modulo-2^IDX_BITS linear wrap.
  assign idx_nxt = IDX_BITS'(wb_next_idx(32'(idx_q), bte_e'(s_bte)));

  // A beat is answered in SINGLE while the cycle is alive, and in BURST
  // only when the master strobes (STB low is a master wait state).
  assign beat  = s_cyc & ((st == SINGLE) | ((st == BURST) & s_stb));
  assign s_ack = beat & ~cur_oor;
  assign s_err = beat &  cur_oor;

  // Write beats use the port for idx_q; read beats use it to prefetch the
  // next word. DAT_R after a write beat is therefore not meaningful.
  assign ram_wr = beat & s_we & ~cur_oor;
  assign ram_be = ram_wr ? s_sel : '0;
  assign ram_rd = (st == IDLE) ? (s_cyc & s_stb & ~idx_oor)
                               : ((st == BURST) & beat & ~s_we & ~nxt_oor);
  assign ram_addr = (st == IDLE) ? idx : (ram_rd ? idx_nxt : idx_q);

  // rd_vld_q masks the RAM output so that DAT_R reads as zero after reset
  // and for out-of-range words, without resetting the RAM itself.
  assign s_dat_r = rd_vld_q ? ram_rdata : '0;

  wb_sram_mem #(
    .DATA_W (WB_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (IDX_BITS)
  ) u_mem (
    .clk   (clk),
    .rd_en (ram_rd),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (s_dat_w),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      idx_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (s_cyc && s_stb) begin
            idx_q    <= idx;
            rd_vld_q <= ~idx_oor;
            // Only CTI=010 opens a burst; every other code is classic.
            st       <= (s_cti == CTI_INCR) ? BURST : SINGLE;
          end
        end
        SINGLE: begin
          st <= IDLE;
        end
        BURST: begin
          if (!s_cyc) begin
            st <= IDLE;
          end else if (s_stb) begin
            idx_q <= idx_nxt;
            if (!s_we) begin
              rd_vld_q <= ~nxt_oor;
            end
            // The master's CTI belongs to the beat being answered now.
            if (cur_oor || (s_cti == CTI_EOB)) begin
              st <= IDLE;
            end
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_sram.sv
module tb_wb_burst_sram;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  resp;   // 0 none, 1 ack, 2 err
    logic [31:0] data;
    logic        is_rd;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [2:0]  cti;
    logic [1:0]  resp;
    logic [31:0] rd;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] bwr[16];
  logic [31:0] bexp[16];

  wb_burst_sram #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .MEM_DEPTH     (1000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_adr   (adr),
    .s_dat_w (dat_w),
    .s_sel   (sel),
    .s_cyc   (cyc),
    .s_stb   (stb),
    .s_we    (we),
    .s_cti   (cti),
    .s_bte   (bte),
    .s_dat_r (dat_r),
    .s_ack   (ack),
    .s_err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic classic(input logic cwe, input logic [31:0] cadr, input logic [3:0] csel,
                         input logic [31:0] cwd, input logic [2:0] ccti,
                         input logic [1:0] eresp, input logic [31:0] erd);
    int          lat;
    logic [1:0]  resp;
    logic [31:0] rd;
    sb_t         e;
    e.resp = eresp; e.data = erd; e.is_rd = ~cwe;
    sb_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = cwe; adr = cadr; sel = csel; dat_w = cwd; cti = ccti; bte = 2'b00;
    lat = 0; resp = 2'd0; rd = '0;
    while (lat < 8) begin
      @(negedge clk);
      if (ack || err) begin
        resp = {err, ack};
        rd   = dat_r;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check("classic_resp", 32'(resp), 32'(e.resp));
    if (e.resp != 2'd0) check("classic_latency", 32'(lat), 32'd1);
    if (e.is_rd && e.resp == 2'd1) check("classic_rdata", rd, e.data);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(negedge clk);
    check("classic_single_pulse", 32'({err, ack}), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic burst(input logic bwe, input logic [31:0] badr, input logic [1:0] bbte,
                       input int n, input int stall_at, input int err_beat);
    int         nb, cc, last_cc, stall_left;
    logic [1:0] resp;
    logic       fin;
    sb_t        e;
    for (int i = 0; i < n; i++) begin
      if (err_beat >= 0 && i > err_beat) break;
      e.resp = (i == err_beat) ? 2'd2 : 2'd1;
      e.data = bexp[i];
      e.is_rd = ~bwe;
      sb_q.push_back(e);
    end
    nb = 0; cc = 0; last_cc = 0; stall_left = 2; fin = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = bwe; adr = badr; bte = bbte; sel = 4'hF;
    cti = 3'b010; dat_w = 32'hBAD0_BAD0;
    while (!fin && cc < 64) begin
      @(negedge clk);
      resp = {err, ack};
      if (!stb) begin
        check("burst_wait_state", 32'(resp), 32'd0);
      end else if (resp != 2'd0) begin
        if (sb_q.size() == 0) begin
          check("burst_extra_resp", 32'(resp), 32'd0);
          fin = 1'b1;
        end else begin
          e = sb_q.pop_front();
          check("burst_resp", 32'(resp), 32'(e.resp));
          if (e.is_rd && resp == 2'd1) check("burst_rdata", dat_r, e.data);
          check("burst_gap", 32'(cc - last_cc), (nb != 0 && nb == stall_at) ? 32'd3 : 32'd1);
          last_cc = cc;
          nb++;
          if (resp != 2'd1 || nb >= n) fin = 1'b1;
        end
      end
      @(posedge clk); #1;
      cc++;
      if (fin) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end else if (nb == stall_at && stall_left > 0) begin
        stb = 1'b0;
        stall_left--;
      end else begin
        stb   = 1'b1;
        cti   = (nb == n - 1) ? 3'b111 : 3'b010;
        dat_w = bwr[nb];
        adr   = 32'hFFFF_FFF0;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    check("burst_completed", 32'(fin), 32'd1);
    sb_q.delete();
    @(negedge clk);
    check("burst_idle_after", 32'({err, ack}), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   acks;
    logic done;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
    sel = '0; cti = '0; bte = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_dat_r", dat_r, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // linear 4-beat write then read-back burst at word 0
    for (int i = 0; i < 4; i++) bwr[i] = 32'(i + 1);
    burst(1'b1, 32'h0, 2'b00, 4, -1, -1);
    for (int i = 0; i < 4; i++) bexp[i] = 32'(i + 1);
    burst(1'b0, 32'h0, 2'b00, 4, -1, -1);

    // preload word i = i
    for (int i = 0; i < 8; i++) classic(1'b1, 32'(4 * i), 4'hF, 32'(i), 3'b000, 2'd1, 32'h0);

    // wrap-4 from word 6 with a two-cycle master stall before beat 2
    bexp[0] = 32'd6; bexp[1] = 32'd7; bexp[2] = 32'd4; bexp[3] = 32'd5;
    burst(1'b0, 32'h18, 2'b01, 4, 2, -1);

    // wrap-8 from word 5
    for (int i = 0; i < 8; i++) bexp[i] = 32'((5 + i) % 8);
    burst(1'b0, 32'h14, 2'b10, 8, -1, -1);

    tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF,    32'hDEAD_BEEF, 3'b000, 2'd1, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 4'hF,    32'h0,         3'b000, 2'd1, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h0000_0010, 4'b0010, 32'h0000_AB00, 3'b001, 2'd1, 32'h0};
    tbl[3]  = '{1'b0, 32'h0000_0010, 4'hF,    32'h0,         3'b111, 2'd1, 32'hDEAD_ABEF};
    tbl[4]  = '{1'b1, 32'h0000_0FA0, 4'hF,    32'h1234_5678, 3'b000, 2'd2, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_0000, 4'hF,    32'h0,         3'b000, 2'd1, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0FA0, 4'hF,    32'h0,         3'b000, 2'd2, 32'h0};
    tbl[7]  = '{1'b0, 32'h1000_0010, 4'hF,    32'h0,         3'b000, 2'd1, 32'hDEAD_ABEF};
    tbl[8]  = '{1'b1, 32'h0000_0F98, 4'hF,    32'h0000_03E6, 3'b011, 2'd1, 32'h0};
    tbl[9]  = '{1'b1, 32'h0000_0F9C, 4'hF,    32'h0000_03E7, 3'b110, 2'd1, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_0F9C, 4'hF,    32'h0,         3'b000, 2'd1, 32'h0000_03E7};
    tbl[11] = '{1'b1, 32'h0000_0FFC, 4'hF,    32'hFFFF_FFFF, 3'b000, 2'd2, 32'h0};
    for (int i = 0; i < 12; i++) begin
      classic(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd, tbl[i].cti, tbl[i].resp, tbl[i].rd);
    end
    classic(1'b0, 32'h0, 4'hF, 32'h0, 3'b000, 2'd1, 32'h0);

    // linear read burst running off the end of memory: ERR on word 1000
    bexp[0] = 32'h3E6; bexp[1] = 32'h3E7; bexp[2] = 32'h0; bexp[3] = 32'h0;
    burst(1'b0, 32'hF98, 2'b00, 4, -1, 2);

    // reset during beat 3 of an 8-beat write burst
    for (int i = 0; i < 8; i++) classic(1'b1, 32'(64 + 4 * i), 4'hF, 32'(32'hA0 + i), 3'b000, 2'd1, 32'h0);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; bte = 2'b00; sel = 4'hF;
    cti = 3'b010; dat_w = 32'hB0;
    acks = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (ack) begin
        if (acks == 2) begin
          rst = 1'b1;
          #1;
          check("rst_async_ack", 32'(ack), 32'd0);
          check("rst_async_dat_r", dat_r, 32'd0);
          done = 1'b1;
        end else begin
          acks++;
        end
      end
      if (!done) begin
        @(posedge clk); #1;
        dat_w = 32'hB0 + 32'(acks);
        cti   = (acks == 7) ? 3'b111 : 3'b010;
      end
    end
    check("rst_mid_burst_reached", 32'(done), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      classic(1'b0, 32'(64 + 4 * i), 4'hF, 32'h0, 3'b000, 2'd1,
              (i < 2) ? 32'(32'hB0 + i) : 32'(32'hA0 + i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
